// File: rtl/crumb_collector_if.sv
// Receive-side bundle of the crumb chain: serial en/bit inputs, word handshake and status.
interface crumb_collector_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH);

    logic             en_i;
    logic             rbit_i;
    logic [WIDTH-1:0] word_o;
    logic             valid_o;
    logic             ready_i;
    logic             overflow_o;
    logic             clr_ovf_i;
    logic [CNT_W-1:0] bit_cnt_o;

    modport slave (
        input  en_i, rbit_i, ready_i, clr_ovf_i,
        output word_o, valid_o, overflow_o, bit_cnt_o
    );

    modport master (
        output en_i, rbit_i, ready_i, clr_ovf_i,
        input  word_o, valid_o, overflow_o, bit_cnt_o
    );
endinterface

// File: rtl/crumb_collector.sv
// Crumb chain terminator: synchronises en/rbit and packs MSB-first bits into WIDTH-bit words.
// valid_o rises SYNC_STAGES edges after the last bit is sampled; a word completing while the held word is stalled is dropped and flagged.
module crumb_collector #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    crumb_collector_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

    logic [SYNC_STAGES-1:0] en_sync_q, en_sync_d;
    logic [SYNC_STAGES-1:0] rbit_sync_q, rbit_sync_d;
    logic [WIDTH-1:0]       shreg_q, shreg_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]       word_q, word_d;
    logic                   valid_q, valid_d;
    logic                   ovf_q, ovf_d;

    logic             en_s;
    logic             rbit_s;
    logic [WIDTH-1:0] next_word;
    logic             complete;

    assign en_s      = en_sync_q[SYNC_STAGES-1];
    assign rbit_s    = rbit_sync_q[SYNC_STAGES-1];
    assign next_word = {shreg_q[WIDTH-2:0], rbit_s};

    always_comb begin
        en_sync_d   = {en_sync_q[SYNC_STAGES-2:0], bus.en_i};
        rbit_sync_d = {rbit_sync_q[SYNC_STAGES-2:0], bus.rbit_i};

        // Idle discards any partial word without flagging it.
        shreg_d   = '0;
        bit_cnt_d = '0;
        complete  = 1'b0;
        if (en_s) begin
            shreg_d = next_word;
            if (bit_cnt_q == CNT_MAX) begin
                complete = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end

        word_d  = word_q;
        valid_d = valid_q;
        ovf_d   = ovf_q & ~bus.clr_ovf_i;
        if (valid_q && bus.ready_i) begin
            valid_d = 1'b0;
        end
        // A drop sets overflow after the clear so a simultaneous set wins.
        if (complete) begin
            if (!valid_q || bus.ready_i) begin
                word_d  = next_word;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_sync_q   <= '0;
            rbit_sync_q <= '0;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            word_q      <= '0;
            valid_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            en_sync_q   <= en_sync_d;
            rbit_sync_q <= rbit_sync_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            word_q      <= word_d;
            valid_q     <= valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.word_o     = word_q;
    assign bus.valid_o    = valid_q;
    assign bus.overflow_o = ovf_q;
    assign bus.bit_cnt_o  = bit_cnt_q;
endmodule
